pingpong_bram: RTL
==================

# pingpong_bram

Double-buffered, parametrised dual-port grid memory for the Conway engine. It holds two banks of DEPTH x DATA_WIDTH cells. The read bank serves the current generation to the neighbourhood logic, and the write bank collects the next generation from the update logic. A single swap request exchanges the two roles. The block also provides a zero-clear sweep after reset and on demand, so the generation loop never reads stale cells.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per cell word
- DEPTH, 200, words per bank; must be 2..2^ADDR_WIDTH
- ADDR_WIDTH, 8, address width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- write_addr  in  ADDR_WIDTH  write-bank address
- write_enable  in  1  write strobe; ignored while busy
- write_data  in  DATA_WIDTH  word to write
- read_addr  in  ADDR_WIDTH  read-bank address
- read_enable  in  1  read strobe; accepted in any state
- read_data  out  DATA_WIDTH  registered read word
- read_valid  out  1  read_data holds the result of an accepted read
- swap_req  in  1  single-cycle request to exchange banks
- clear_req  in  1  single-cycle request to zero the write bank
- swap_done  out  1  one-cycle pulse when a swap takes effect
- busy  out  1  a clear sweep is in progress
- active_bank  out  1  index of the current read bank; the write bank is ~active_bank

## Operation
- FSM states:
  - CLEAR_ALL: entered on reset. Zeros both banks in parallel, one address per cycle, 0..DEPTH-1. Moves to IDLE after address DEPTH-1.
  - IDLE: normal operation.
  - CLEAR_WR: zeros the write bank only, one address per cycle. Moves to IDLE after address DEPTH-1.
- busy = 1 in CLEAR_ALL and CLEAR_WR.
- Writes:
  - Go only to the write bank.
  - Ignored while busy or when write_addr >= DEPTH.
- Reads:
  - Come only from the read bank.
  - If read_addr >= DEPTH, return 0 with read_valid asserted.
  - Accepted in every state. During CLEAR_ALL they return whatever the bank currently holds.
- Bank selection is sampled when a read or write is issued. A read issued in the same cycle that a swap is accepted reads the old read bank.
- Swap:
  - swap_req in IDLE toggles active_bank at the next edge, and swap_done pulses in that same cycle.
  - swap_req while busy is latched as pending. It executes on the first IDLE cycle, and swap_done pulses then.
  - Only one pending swap is held; further requests are OR-merged into it.
- Simultaneous swap_req and clear_req in IDLE: the swap takes effect first, then CLEAR_WR sweeps the new write bank (the old read bank).
- clear_req while busy is ignored.
- Clear counter width is ADDR_WIDTH. The terminal compare is against DEPTH-1, not against counter wrap.

## Timing
- Reset values:
  - read_data = 0, read_valid = 0, swap_done = 0, active_bank = 0
  - busy = 1, state = CLEAR_ALL, clear counter = 0, swap pending = 0
- Read latency is 1 cycle: read_enable at edge N gives read_data and read_valid at edge N+1. With READ_PIPE_EN it is 2 cycles.
- read_data holds its last value when no read is issued. read_valid is a one-cycle pulse per accepted read.
- A write at edge N is visible to reads only after a swap, because writes and reads never target the same bank.
- A sweep after reset or clear_req lasts DEPTH cycles. busy falls on the cycle after address DEPTH-1 is written.
- swap_done latency from swap_req:
  - in IDLE: 1 cycle
  - while busy: the first cycle after busy falls
- Reset asserted mid-sweep or mid-read:
  - Returns immediately to the reset values.
  - Drops the pending swap.
  - Restarts CLEAR_ALL from address 0.

## Configuration
- READ_PIPE_EN defined: adds a second output register. Read latency becomes 2, read_valid is delayed to match, and both pipeline stages reset to 0.
- READ_PIPE_EN undefined: a single registered output with latency 1.

## Structure
- pingpong_bram_pkg holds:
  - the FSM state enum (CLEAR_ALL, IDLE, CLEAR_WR)
  - the bank-index constants
  - the READ_LATENCY constant derived from READ_PIPE_EN
- Sub-module bram_bank: one simple dual-port, non-reset memory array with a synchronous registered read. It is instantiated twice; the top level does the muxing, sweep and FSM.

## Test plan
- Reset, then wait: busy is high for exactly 200 cycles; reading addresses 0, 57 and 199 afterwards returns 0 with read_valid one cycle after read_enable.
- Write 0xA5 to address 10, read address 10 before any swap, then swap_req: the first read returns 0; swap_done pulses one cycle after the request, active_bank becomes 1, and reading address 10 then returns 0xA5.
- Write 0x3C to address 199, swap, then clear_req: busy is high for 200 cycles; reading address 199 still returns 0x3C, because the sweep zeros only the new write bank. Swap again, and address 199 reads 0.
- swap_req and clear_req in the same IDLE cycle: active_bank toggles on the next edge, then a 200-cycle sweep runs. A swap_req issued mid-sweep produces swap_done exactly one cycle after busy falls.
- write_enable with address 250 and read_enable with address 250: no bank contents change, and read_data returns 0 with read_valid asserted.
- Assert reset 50 cycles into a clear sweep: outputs return to their reset values immediately. After release, busy stays high for a full 200 cycles. With READ_PIPE_EN defined, read_valid arrives 2 cycles after read_enable.

Source files
------------

// File: rtl/pingpong_bram_pkg.sv
// pingpong_bram_pkg: FSM states, bank indices and read latency for pingpong_bram (READ_PIPE_EN adds a pipeline stage)
package pingpong_bram_pkg;
  typedef enum logic [1:0] {CLEAR_ALL = 2'd0, IDLE = 2'd1, CLEAR_WR = 2'd2} state_t;
  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;
`ifdef READ_PIPE_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif
endpackage

// File: rtl/bram_bank.sv
// bram_bank: simple dual-port memory bank with synchronous registered read, no reset on the array or read register
module bram_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 200,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pingpong_bram.sv
// pingpong_bram: double-buffered grid memory with bank swap and zero-clear sweeps.
// Define READ_PIPE_EN for a second output register (read latency 2).
module pingpong_bram
  import pingpong_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 200,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  input  logic                  swap_req,
  input  logic                  clear_req,
  output logic                  swap_done,
  output logic                  busy,
  output logic                  active_bank
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt, waddr;
  logic [DATA_WIDTH-1:0] wdata, q0, q1, d1;
  logic [1:0] we, re;
  logic pend, wr_ok, rd_ok, swap_now, rd_sel, rd_hit, v1;
  assign busy     = state != IDLE;
  assign wr_ok    = write_enable && !busy && 32'(write_addr) < DEPTH;
  assign rd_ok    = 32'(read_addr) < DEPTH;
  assign swap_now = !busy && (swap_req || pend);
  assign waddr    = busy ? cnt : write_addr;
  assign wdata    = busy ? '0 : write_data;
  // CLEAR_ALL hits both banks; everything else targets only the write bank
  assign we[BANK0] = state == CLEAR_ALL || ((busy || wr_ok) && active_bank != BANK0);
  assign we[BANK1] = state == CLEAR_ALL || ((busy || wr_ok) && active_bank != BANK1);
  assign re[BANK0] = read_enable && rd_ok && active_bank == BANK0;
  assign re[BANK1] = read_enable && rd_ok && active_bank == BANK1;
  bram_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
    .clk(clk), .we(we[BANK0]), .waddr(waddr), .wdata(wdata),
    .re(re[BANK0]), .raddr(read_addr), .rdata(q0)
  );
  bram_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
    .clk(clk), .we(we[BANK1]), .waddr(waddr), .wdata(wdata),
    .re(re[BANK1]), .raddr(read_addr), .rdata(q1)
  );
  // rd_hit gates the non-reset bank registers so read_data is 0 after reset and for out-of-range reads
  assign d1 = rd_hit ? (rd_sel ? q1 : q0) : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLEAR_ALL;
      cnt         <= '0;
      pend        <= 1'b0;
      active_bank <= BANK0;
      swap_done   <= 1'b0;
      rd_sel      <= 1'b0;
      rd_hit      <= 1'b0;
      v1          <= 1'b0;
    end else begin
      swap_done <= swap_now;
      pend      <= busy && (pend || swap_req);
      v1        <= read_enable;
      if (swap_now) active_bank <= ~active_bank;
      if (read_enable) begin
        rd_sel <= active_bank;
        rd_hit <= rd_ok;
      end
      if (busy) begin
        cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
        state <= cnt == LAST ? IDLE : state;
      end else if (clear_req) state <= CLEAR_WR;
    end
  end
  if (READ_LATENCY > 1) begin : g_pipe
    logic [DATA_WIDTH-1:0] d2;
    logic v2;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        d2 <= '0;
        v2 <= 1'b0;
      end else begin
        d2 <= d1;
        v2 <= v1;
      end
    end
    assign read_data  = d2;
    assign read_valid = v2;
  end else begin : g_direct
    assign read_data  = d1;
    assign read_valid = v1;
  end
endmodule
